multimode_lap_timer: RTL and testbench

MULTIMODE_LAP_TIMER -- requirements
Module: multimode_lap_timer

---
 rtl/timer_pkg.sv | 15 +
 rtl/bcd_digit.sv | 27 ++
 rtl/multimode_lap_timer.sv | 161 ++++++++++++++++
 tb/tb_multimode_lap_timer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types for the multimode lap timer: FSM states and the BCD digit type.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One up/down BCD decade: steps only when enabled with carry/borrow in, and
// reports carry (9->0) or borrow (0->9) to the next decade.
module bcd_digit
  import timer_pkg::*;
(
  input  logic i_en,
  input  logic i_up,
  input  logic i_cin,
  input  bcd_t i_q,
  output bcd_t o_q,
  output logic o_cout
);

  logic w_step;

  assign w_step = i_en & i_cin;
  assign o_cout = w_step & (i_up ? (i_q >= BCD_MAX) : (i_q == 4'd0));

  always_comb begin
    o_q = i_q;
    if (w_step) begin
      if (i_up) o_q = (i_q >= BCD_MAX) ? 4'd0 : i_q + 4'd1;
      else      o_q = (i_q == 4'd0) ? BCD_MAX : i_q - 4'd1;
    end
  end

endmodule

// File: rtl/multimode_lap_timer.sv
// Stopwatch / countdown timer with BCD display, prescaled count tick and a
// small lap memory that can be recalled onto the display.
module multimode_lap_timer
  import timer_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 12_000_000,
  parameter int LAP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_stop,
  input  logic                         lap,
  input  logic                         clear,
  input  logic                         mode,
  input  logic [4*DIGITS-1:0]          load_val,
  input  logic                         recall,
  input  logic [$clog2(LAP_DEPTH)-1:0] recall_idx,
  output logic [4*DIGITS-1:0]          digits,
  output logic                         running,
  output logic                         time_up,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_full
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAP_MAX  = CNT_W'(LAP_DEPTH);

  function automatic logic [W-1:0] sat_load(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = (v[4*i +: 4] > BCD_MAX) ? BCD_MAX : v[4*i +: 4];
    return r;
  endfunction

  state_t             r_state, w_state_nxt;
  logic               r_mode;
  logic [PRE_W-1:0]   r_pre, w_pre_nxt;
  logic [W-1:0]       r_count, w_count_nxt, w_count_step;
  logic [W-1:0]       r_lap_mem [LAP_DEPTH];
  logic [CNT_W-1:0]   r_lap_cnt, w_lap_cnt_nxt;
  logic [DIGITS:0]    w_carry;
  logic               w_mode_now, w_tick, w_clear, w_lap_we, w_done_hit;
  logic [W-1:0]       w_lap_sel, w_digits_nxt;
  logic               w_running_nxt, w_time_up_nxt, w_lap_full_nxt;
  logic [W-1:0]       r_digits;
  logic               r_running, r_time_up, r_lap_full;

  // In IDLE the live mode input is authoritative; elsewhere the latched copy.
  assign w_mode_now = (r_state == IDLE) ? mode : r_mode;
  assign w_tick     = (r_state == RUN) && (r_pre == PRE_LAST);
  assign w_clear    = clear && (r_state != RUN);
  assign w_lap_we   = lap && (r_state == RUN) && (r_lap_cnt < LAP_MAX);

  assign w_carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .i_en   (w_tick),
      .i_up   (~r_mode),
      .i_cin  (w_carry[g]),
      .i_q    (r_count[4*g +: 4]),
      .o_q    (w_count_step[4*g +: 4]),
      .o_cout (w_carry[g+1])
    );
  end

  // A countdown never wraps through zero: reaching it (or borrowing past it) ends the run.
  assign w_done_hit = w_tick & r_mode & ((w_count_step == '0) | w_carry[DIGITS]);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start_stop && !(w_mode_now && (r_count == '0))) w_state_nxt = RUN;
        RUN:     if (w_done_hit) w_state_nxt = DONE;
                 else if (start_stop) w_state_nxt = PAUSE;
        PAUSE:   if (start_stop) w_state_nxt = RUN;
        DONE:    if (start_stop) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_clear)         w_count_nxt = w_mode_now ? sat_load(load_val) : '0;
    else if (w_done_hit) w_count_nxt = '0;
    else if (w_tick)     w_count_nxt = w_count_step;

    w_pre_nxt = r_pre;
    if (w_clear || ((r_state == IDLE) && (w_state_nxt == RUN))) w_pre_nxt = '0;
    else if (r_state == RUN) w_pre_nxt = w_tick ? '0 : r_pre + PRE_W'(1);

    w_lap_cnt_nxt = r_lap_cnt;
    if (w_clear)       w_lap_cnt_nxt = '0;
    else if (w_lap_we) w_lap_cnt_nxt = r_lap_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode    <= 1'b0;
      r_pre     <= '0;
      r_count   <= '0;
      r_lap_cnt <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) r_lap_mem[i] <= '0;
    end else begin
      if (r_state == IDLE) r_mode <= mode;
      r_pre     <= w_pre_nxt;
      r_count   <= w_count_nxt;
      r_lap_cnt <= w_lap_cnt_nxt;
      if (w_clear) begin
        for (int i = 0; i < LAP_DEPTH; i++) r_lap_mem[i] <= '0;
      end else if (w_lap_we) begin
        r_lap_mem[r_lap_cnt[IDX_W-1:0]] <= r_count;
      end
    end
  end

  // Outputs are registered from next-state values so they track the internal state.
  always_comb begin
    if (w_lap_we && (recall_idx == r_lap_cnt[IDX_W-1:0])) w_lap_sel = r_count;
    else                                                  w_lap_sel = r_lap_mem[recall_idx];
    w_digits_nxt = w_count_nxt;
    if (recall) w_digits_nxt = ({1'b0, recall_idx} < w_lap_cnt_nxt) ? w_lap_sel : '0;
    w_running_nxt  = (w_state_nxt == RUN);
    w_time_up_nxt  = (w_state_nxt == DONE);
    w_lap_full_nxt = (w_lap_cnt_nxt == LAP_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits   <= '0;
      r_running  <= 1'b0;
      r_time_up  <= 1'b0;
      r_lap_full <= 1'b0;
    end else begin
      r_digits   <= w_digits_nxt;
      r_running  <= w_running_nxt;
      r_time_up  <= w_time_up_nxt;
      r_lap_full <= w_lap_full_nxt;
    end
  end

  assign digits    = r_digits;
  assign running   = r_running;
  assign time_up   = r_time_up;
  assign lap_count = r_lap_cnt;
  assign lap_full  = r_lap_full;

endmodule

// File: tb/tb_multimode_lap_timer.sv
// Bench for multimode_lap_timer: integer-level timer model checked every cycle
// plus directed scenarios with hand-computed display values.
module tb_multimode_lap_timer;

  localparam int DIGITS    = 2;
  localparam int CLK_DIV   = 4;
  localparam int LAP_DEPTH = 2;
  localparam int MAXV      = 100;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       reset, start_stop, lap, clear, mode, recall;
  logic [7:0] load_val;
  logic       recall_idx;
  logic [7:0] digits;
  logic       running, time_up, lap_full;
  logic [1:0] lap_count;

  int n_checks = 0;
  int n_err    = 0;

  multimode_lap_timer #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .LAP_DEPTH(LAP_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap),
    .clear(clear), .mode(mode), .load_val(load_val), .recall(recall),
    .recall_idx(recall_idx), .digits(digits), .running(running),
    .time_up(time_up), .lap_count(lap_count), .lap_full(lap_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    int t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_dec(input logic [7:0] v);
    int acc, w, d;
    acc = 0;
    w   = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      acc += d * w;
      w   *= 10;
    end
    return acc;
  endfunction

  // Behavioural model: decimal count, prescaler phase, state and lap list.
  int m_st, m_nst, m_cnt, m_ncnt, m_pre, m_mreg, m_lapn, m_mode_now;
  int m_laps [LAP_DEPTH];
  bit m_tick, m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_st = S_IDLE; m_cnt = 0; m_pre = 0; m_mreg = 0; m_lapn = 0;
      for (int i = 0; i < LAP_DEPTH; i++) m_laps[i] = 0;
    end else begin
      m_mode_now = (m_st == S_IDLE) ? int'(mode) : m_mreg;
      m_tick     = (m_st == S_RUN) && (m_pre == CLK_DIV - 1);
      m_nst      = m_st;
      if (clear && m_st != S_RUN) begin
        m_cnt  = (m_mode_now != 0) ? load_dec(load_val) : 0;
        m_pre  = 0;
        m_lapn = 0;
        for (int i = 0; i < LAP_DEPTH; i++) m_laps[i] = 0;
        m_nst  = S_IDLE;
      end else begin
        if (m_st == S_RUN && lap && m_lapn < LAP_DEPTH) begin
          m_laps[m_lapn] = m_cnt;
          m_lapn++;
        end
        m_ncnt = m_cnt;
        if (m_tick) m_ncnt = (m_mreg != 0) ? m_cnt - 1 : (m_cnt + 1) % MAXV;
        case (m_st)
          S_IDLE:  if (start_stop && !(m_mode_now != 0 && m_cnt == 0)) begin
                     m_nst = S_RUN;
                     m_pre = 0;
                   end
          S_RUN:   begin
                     m_pre = (m_pre + 1) % CLK_DIV;
                     if (m_tick && m_mreg != 0 && m_ncnt == 0) m_nst = S_DONE;
                     else if (start_stop) m_nst = S_PAUSE;
                   end
          S_PAUSE: if (start_stop) m_nst = S_RUN;
          default: if (start_stop) m_nst = S_IDLE;
        endcase
        m_cnt = m_ncnt;
      end
      if (m_st == S_IDLE) m_mreg = int'(mode);
      m_st = m_nst;
    end
    m_valid = 1'b1;
  end

  // Every-cycle comparison against the model, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      if (recall)
        chk("model_digits", digits,
            to_bcd((int'(recall_idx) < m_lapn) ? m_laps[recall_idx] : 0));
      else
        chk("model_digits", digits, to_bcd(m_cnt));
      chk("model_running",   running,   (m_st == S_RUN));
      chk("model_time_up",   time_up,   (m_st == S_DONE));
      chk("model_lap_count", lap_count, m_lapn);
      chk("model_lap_full",  lap_full,  (m_lapn == LAP_DEPTH));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; @(negedge clk); lap = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; mode = 1'b0;
    recall = 1'b0; recall_idx = 1'b0; load_val = 8'h00;
    cyc(3);
    reset = 1'b0;
    chk("reset_digits", digits, 8'h00);
    chk("reset_running", running, 1'b0);
    chk("reset_time_up", time_up, 1'b0);
    chk("reset_lap_count", lap_count, 2'd0);
    chk("reset_lap_full", lap_full, 1'b0);

    // Stopwatch: 40 cycles -> 10 ticks
    pulse_ss();
    cyc(40);
    chk("up40_digits", digits, 8'h10);
    chk("up40_running", running, 1'b1);

    // Run to 99 then wrap to 00 while running
    cyc(356);
    chk("up99_digits", digits, 8'h99);
    cyc(4);
    chk("wrap_digits", digits, 8'h00);
    chk("wrap_running", running, 1'b1);

    // Countdown from 03
    pulse_ss();
    chk("pause_running", running, 1'b0);
    mode = 1'b1; load_val = 8'h03;
    pulse_clr();
    chk("clr_pause_mode0", digits, 8'h00);
    pulse_clr();
    chk("clr_load_03", digits, 8'h03);
    pulse_ss();
    cyc(12);
    chk("down_time_up", time_up, 1'b1);
    chk("down_digits", digits, 8'h00);
    chk("down_running", running, 1'b0);
    pulse_ss();
    chk("done_to_idle_time_up", time_up, 1'b0);
    chk("done_to_idle_running", running, 1'b0);
    pulse_ss();
    chk("zero_start_ignored", running, 1'b0);

    // Preset digits above 9 saturate
    load_val = 8'hA5;
    pulse_clr();
    chk("sat_load", digits, 8'h95);
    mode = 1'b0;
    pulse_clr();
    chk("clr_mode0", digits, 8'h00);

    // Laps at counts 2, 5, 7 with depth 2
    pulse_ss();
    cyc(8);
    pulse_lap();
    cyc(11);
    pulse_lap();
    cyc(7);
    pulse_lap();
    chk("lap_count_full", lap_count, 2'd2);
    chk("lap_full", lap_full, 1'b1);
    recall = 1'b1; recall_idx = 1'b1;
    cyc(1);
    chk("recall1", digits, 8'h05);
    recall_idx = 1'b0;
    cyc(1);
    chk("recall0", digits, 8'h02);
    recall = 1'b0;

    // Pause/resume keeps prescaler phase
    pulse_ss();
    pulse_clr();
    chk("clr_laps", lap_count, 2'd0);
    recall = 1'b1; recall_idx = 1'b1;
    cyc(1);
    chk("recall_empty", digits, 8'h00);
    recall = 1'b0;
    pulse_ss();
    cyc(12);
    pulse_ss();
    chk("pause_at3_running", running, 1'b0);
    chk("pause_at3_digits", digits, 8'h03);
    cyc(20);
    chk("paused_hold", digits, 8'h03);
    pulse_ss();
    chk("resume_running", running, 1'b1);
    cyc(2);
    chk("resume_phase_3", digits, 8'h03);
    cyc(1);
    chk("resume_phase_4", digits, 8'h04);

    // Reset mid-run at 42
    pulse_lap();
    cyc(151);
    chk("pre_reset_digits", digits, 8'h42);
    chk("pre_reset_laps", lap_count, 2'd1);
    reset = 1'b1;
    cyc(1);
    chk("midrun_reset_digits", digits, 8'h00);
    chk("midrun_reset_running", running, 1'b0);
    chk("midrun_reset_laps", lap_count, 2'd0);
    reset = 1'b0;
    cyc(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
